// File: rtl/unary_pkg.sv
// Shared types and defaults for the unary stream generator, the unary adder and their benches.
package unary_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } unary_state_t;

  localparam int UNARY_CNT_W      = 4;
  localparam int UNARY_STREAM_LEN = 16;
  localparam int UNARY_DRAIN_LEN  = 16;

  function automatic int unary_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/unary_stream_gen_if.sv
// Operand handshake plus adder-facing control/stream signals of the unary stream generator.
interface unary_stream_gen_if
  import unary_pkg::*;
#(
  parameter int CNT_W = UNARY_CNT_W
) ();

  // Handshake: an operand pair transfers on a rising edge where in_valid and in_ready are both 1;
  // op_a/op_b are only sampled on that edge, and in_valid while in_ready is 0 is simply ignored.
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] op_a;
  logic [CNT_W-1:0] op_b;
  logic             a_bit;
  logic             b_bit;
  logic             en;
  logic             read_or_write;
  logic             busy;
  logic             done;
  unary_state_t     dbg_state;

  modport master (
    output in_valid, op_a, op_b,
    input  in_ready, a_bit, b_bit, en, read_or_write, busy, done, dbg_state
  );

  modport slave (
    input  in_valid, op_a, op_b,
    output in_ready, a_bit, b_bit, en, read_or_write, busy, done, dbg_state
  );

endinterface

// File: rtl/unary_bit_enc.sv
// Registered thermometer encoder: emits 1 while the index is below the value, so ones come first.
module unary_bit_enc
  import unary_pkg::*;
#(
  parameter int CNT_W = UNARY_CNT_W,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             bit_o
);

  localparam int CMP_W = unary_max(CNT_W, IDX_W);

  logic [CMP_W-1:0] val_ext;
  logic [CMP_W-1:0] idx_ext;
  logic             bit_d;
  logic             bit_q;

  // Both sides zero-extended so the compare stays unsigned whichever operand is wider.
  always_comb begin
    val_ext = CMP_W'(val_i);
    idx_ext = CMP_W'(idx_i);
    bit_d   = en_i && (idx_ext < val_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/unary_stream_gen.sv
// Sequencer that turns a binary operand pair into unary streams for the adder: STREAM, then DRAIN.
module unary_stream_gen
  import unary_pkg::*;
#(
  parameter int CNT_W      = UNARY_CNT_W,
  parameter int STREAM_LEN = UNARY_STREAM_LEN,
  parameter int DRAIN_LEN  = UNARY_DRAIN_LEN
) (
  input logic               clk,
  input logic               rst_n,
  unary_stream_gen_if.slave bus
);

  localparam int IDX_W = unary_max(1, $clog2(unary_max(STREAM_LEN, DRAIN_LEN)));
  localparam logic [IDX_W-1:0] STREAM_LAST = IDX_W'(STREAM_LEN - 1);
  localparam logic [IDX_W-1:0] DRAIN_LAST  = IDX_W'(DRAIN_LEN - 1);

  unary_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] op_a_q, op_a_d;
  logic [CNT_W-1:0] op_b_q, op_b_d;
  logic             in_ready_q, in_ready_d;
  logic             en_q, en_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stream_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = S_STREAM;
          idx_d   = '0;
          op_a_d  = bus.op_a;
          op_b_d  = bus.op_b;
        end
      end
      S_STREAM: begin
        if (idx_q == STREAM_LAST) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (idx_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so every output register lines up with its phase.
    stream_d   = (state_d == S_STREAM);
    in_ready_d = (state_d == S_IDLE);
    en_d       = (state_d != S_IDLE);
    rw_d       = (state_d == S_DRAIN);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      in_ready_q <= 1'b0;
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      in_ready_q <= in_ready_d;
      en_q       <= en_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  unary_bit_enc #(
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_enc_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stream_d),
    .val_i (op_a_d),
    .idx_i (idx_d),
    .bit_o (bus.a_bit)
  );

  unary_bit_enc #(
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_enc_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stream_d),
    .val_i (op_b_d),
    .idx_i (idx_d),
    .bit_o (bus.b_bit)
  );

  assign bus.in_ready      = in_ready_q;
  assign bus.en            = en_q;
  assign bus.read_or_write = rw_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Self-checking bench: cycle-by-cycle comparison against a model indexed by cycles since handshake.
module tb_unary_stream_gen;
  import unary_pkg::*;

  localparam int CNT_W = 4;
  localparam int S     = 16;
  localparam int D     = 16;
  localparam int BIG   = 1000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unary_stream_gen_if #(.CNT_W(CNT_W)) bus ();

  unary_stream_gen #(
    .CNT_W      (CNT_W),
    .STREAM_LEN (S),
    .DRAIN_LEN  (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {in_ready, a_bit, b_bit, en, read_or_write, busy, done}
  logic [6:0] obs_vec;
  assign obs_vec = {bus.in_ready, bus.a_bit, bus.b_bit, bus.en, bus.read_or_write, bus.busy, bus.done};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected outputs depend only on how many cycles have passed since the last accepted handshake.
  function automatic logic [6:0] model_vec(input int c, input int oa, input int ob, input bit armed);
    logic a, b;
    a = ((c - 1) < oa);
    b = ((c - 1) < ob);
    if (c >= 1 && c <= S)              return {1'b0, a, b, 1'b1, 1'b0, 1'b1, 1'b0};
    else if (c > S && c <= S + D)      return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    else if (c == S + D + 1)           return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    else                               return {armed, 6'b0};
  endfunction

  logic [6:0] exp_q[$];
  int m_c      = BIG;
  int m_oa     = 0;
  int m_ob     = 0;
  bit m_armed  = 1'b0;
  bit m_ready  = 1'b0;
  int done_exp = 0;
  int done_obs = 0;

  always @(negedge rst_n) begin
    exp_q.delete();
    m_c     = BIG;
    m_armed = 1'b0;
    m_ready = 1'b0;
  end

  always @(posedge clk) begin
    logic [6:0] v;
    if (!rst_n) begin
      v = '0;
    end else begin
      if (bus.in_valid === 1'b1 && m_ready) begin
        m_c  = 1;
        m_oa = int'(bus.op_a);
        m_ob = int'(bus.op_b);
      end else if (m_c < BIG) begin
        m_c++;
      end
      m_armed = 1'b1;
      v = model_vec(m_c, m_oa, m_ob, m_armed);
      m_ready = v[6];
      if (v[0]) done_exp++;
    end
    exp_q.push_back(v);
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_obs++;
    if (exp_q.size() > 0) check("outputs", 32'(obs_vec), 32'(exp_q.pop_front()));
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.op_a     = CNT_W'($urandom_range(0, 15));
    bus.op_b     = CNT_W'($urandom_range(0, 15));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves in_valid high on return; the caller decides whether to chain another pair.
  task automatic send(input int a, input int b);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.op_a     = CNT_W'(a);
    bus.op_b     = CNT_W'(b);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("hs_timeout", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy === 1'b0 && bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vec", 32'(obs_vec), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // basic
    send(3, 5);
    idle_inputs();
    wait_idle();

    // operand boundaries
    send(0, 15);
    idle_inputs();
    wait_idle();

    // back-to-back: second pair lands in the done cycle
    send(2, 4);
    send(7, 1);
    idle_inputs();
    wait_idle();

    // in_valid while busy must be ignored
    send(6, 11);
    idle_inputs();
    wait_cycles(4);
    bus.in_valid = 1'b1;
    bus.op_a     = 4'd9;
    bus.op_b     = 4'd9;
    wait_cycles(15);
    idle_inputs();
    wait_idle();

    // asynchronous reset in the middle of STREAM
    send(10, 12);
    idle_inputs();
    wait_cycles(7);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'(obs_vec), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    send(1, 1);
    idle_inputs();
    wait_idle();

    // randomized pairs with stray in_valid pulses while busy
    for (int t = 0; t < 10; t++) begin
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      idle_inputs();
      wait_cycles(int'($urandom_range(1, 8)));
      bus.in_valid = 1'b1;
      wait_cycles(int'($urandom_range(1, 5)));
      idle_inputs();
      wait_idle();
      wait_cycles(int'($urandom_range(0, 3)));
    end

    wait_cycles(5);
    check("done_count", 32'(done_obs), 32'(done_exp));
    check("dbg_state", 32'(bus.dbg_state), 32'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
